// File: rtl/reg_scoreboard_pkg.sv
// rtl/reg_scoreboard_pkg.sv - shared widths and types for the register scoreboard
package sb_pkg;

    localparam int NUM_REGS   = 32;
    localparam int CNT_W      = 2;
    localparam int REG_W      = $clog2(NUM_REGS);
    localparam int SB_CNT_MAX = (1 << CNT_W) - 1;

    typedef logic [CNT_W-1:0] t_sb_cnt;
    typedef logic [REG_W-1:0] t_sb_reg;

endpackage

// File: rtl/reg_scoreboard_if.sv
// rtl/reg_scoreboard_if.sv - dispatch, writeback and status bundle of the scoreboard
interface reg_scoreboard_if #(
    parameter int NUM_SRCS = 2,
    parameter int NUM_WB   = 2
);
    logic                                    flush;
    logic                                    disp_valid;
    logic [NUM_SRCS-1:0]                     disp_src_valid;
    logic [NUM_SRCS-1:0][sb_pkg::REG_W-1:0]  disp_src;
    logic                                    disp_dst_valid;
    logic [sb_pkg::REG_W-1:0]                disp_dst;
    logic                                    stall;
    logic                                    disp_fire;
    logic [NUM_WB-1:0]                       wb_valid;
    logic [NUM_WB-1:0][sb_pkg::REG_W-1:0]    wb_dst;
    logic [sb_pkg::NUM_REGS-1:0]             pending_mask;
    logic                                    idle;

    modport master (
        output flush, disp_valid, disp_src_valid, disp_src, disp_dst_valid, disp_dst,
        output wb_valid, wb_dst,
        input  stall, disp_fire, pending_mask, idle
    );

    modport slave (
        input  flush, disp_valid, disp_src_valid, disp_src, disp_dst_valid, disp_dst,
        input  wb_valid, wb_dst,
        output stall, disp_fire, pending_mask, idle
    );
endinterface

// File: rtl/reg_scoreboard_counter.sv
// rtl/reg_scoreboard_counter.sv - in-flight writer counter for one architectural register
module sb_reg_counter
    import sb_pkg::*;
#(
    parameter int DEC_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_flush,
    input  logic             i_inc,
    input  logic [DEC_W-1:0] i_dec,
    output t_sb_cnt          o_cnt,
    output logic             o_nonzero,
    output logic             o_at_max
);
    localparam int SUM_W = CNT_W + DEC_W + 1;

    t_sb_cnt          r_cnt;
    logic [SUM_W-1:0] w_up;
    logic [SUM_W-1:0] w_down;
    logic [SUM_W-1:0] w_net;

    // Widened so inc and dec net out before clamping; a same-cycle pair never shows as pending.
    assign w_up   = SUM_W'(r_cnt) + SUM_W'(i_inc);
    assign w_down = SUM_W'(i_dec);
    assign w_net  = (w_down > w_up) ? '0 : (w_up - w_down);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_flush) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_net[CNT_W-1:0];
        end
    end

    assign o_cnt     = r_cnt;
    assign o_nonzero = (r_cnt != '0);
    assign o_at_max  = (r_cnt == t_sb_cnt'(SB_CNT_MAX));

    a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
        !i_flush |-> (w_down <= w_up));
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !i_flush |-> (w_net <= SUM_W'(SB_CNT_MAX)));

endmodule

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - counting register-hazard scoreboard between decode and register read
module reg_scoreboard
    import sb_pkg::*;
#(
    parameter int NUM_SRCS  = 2,
    parameter int NUM_WB    = 2,
    parameter int WB_BYPASS = 0
) (
    input  logic            clk,
    input  logic            reset,
    reg_scoreboard_if.slave sb
);
    localparam int DEC_W = $clog2(NUM_WB + 1);

    t_sb_cnt             w_cnt [NUM_REGS];
    logic [DEC_W-1:0]    w_dec [NUM_REGS];
    logic [NUM_REGS-1:0] w_nonzero;
    logic [NUM_REGS-1:0] w_at_max;
    logic [NUM_REGS-1:0] w_wb_any;
    logic [NUM_REGS-1:0] w_inc;
    logic [NUM_SRCS-1:0] w_src_hit;
    logic                w_dst_sat;
    logic                w_stall_raw;

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            w_dec[r] = '0;
            for (int p = 0; p < NUM_WB; p++) begin
                if (r != 0 && sb.wb_valid[p] && sb.wb_dst[p] == REG_W'(r)) begin
                    w_dec[r] = w_dec[r] + DEC_W'(1);
                end
            end
            w_wb_any[r] = (w_dec[r] != '0);
        end
    end

    // A bypassed writeback only frees a source whose last in-flight writer it retires.
    always_comb begin
        w_src_hit = '0;
        for (int i = 0; i < NUM_SRCS; i++) begin
            if (sb.disp_src_valid[i] && sb.disp_src[i] != '0 && w_nonzero[sb.disp_src[i]]) begin
                w_src_hit[i] = 1'b1;
                if (WB_BYPASS != 0 && w_cnt[sb.disp_src[i]] == t_sb_cnt'(1)
                    && w_wb_any[sb.disp_src[i]]) begin
                    w_src_hit[i] = 1'b0;
                end
            end
        end
    end

    assign w_dst_sat = sb.disp_dst_valid && sb.disp_dst != '0 && w_at_max[sb.disp_dst]
                       && !(WB_BYPASS != 0 && w_wb_any[sb.disp_dst]);

    assign w_stall_raw  = sb.disp_valid && ((|w_src_hit) || w_dst_sat);
    assign sb.stall     = reset && w_stall_raw;
    assign sb.disp_fire = reset && sb.disp_valid && !w_stall_raw && !sb.flush;

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            w_inc[r] = (r != 0) && sb.disp_fire && sb.disp_dst_valid
                       && sb.disp_dst == REG_W'(r);
        end
    end

    assign w_cnt[0]     = '0;
    assign w_nonzero[0] = 1'b0;
    assign w_at_max[0]  = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
        sb_reg_counter #(
            .DEC_W (DEC_W)
        ) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .i_flush   (sb.flush),
            .i_inc     (w_inc[r]),
            .i_dec     (w_dec[r]),
            .o_cnt     (w_cnt[r]),
            .o_nonzero (w_nonzero[r]),
            .o_at_max  (w_at_max[r])
        );
    end

    assign sb.pending_mask = w_nonzero;
    assign sb.idle         = ~|w_nonzero;

    a_fire_not_stall: assert property (@(posedge clk) disable iff (!reset)
        sb.disp_fire |-> !sb.stall);

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - randomized and directed check of reg_scoreboard without and with WB bypass
module tb_reg_scoreboard;
    import sb_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst_n;
    logic                  flush, disp_valid, dst_valid;
    logic [1:0]            src_valid;
    logic [1:0][REG_W-1:0] src;
    t_sb_reg               dst;
    logic [1:0]            wb_valid;
    logic [1:0][REG_W-1:0] wb_dst;

    reg_scoreboard_if #(.NUM_SRCS(2), .NUM_WB(2)) if0 ();
    reg_scoreboard_if #(.NUM_SRCS(2), .NUM_WB(2)) if1 ();

    assign if0.flush = flush;                   assign if1.flush = flush;
    assign if0.disp_valid = disp_valid;         assign if1.disp_valid = disp_valid;
    assign if0.disp_src_valid = src_valid;      assign if1.disp_src_valid = src_valid;
    assign if0.disp_src = src;                  assign if1.disp_src = src;
    assign if0.disp_dst_valid = dst_valid;      assign if1.disp_dst_valid = dst_valid;
    assign if0.disp_dst = dst;                  assign if1.disp_dst = dst;
    assign if0.wb_valid = wb_valid;             assign if1.wb_valid = wb_valid;
    assign if0.wb_dst = wb_dst;                 assign if1.wb_dst = wb_dst;

    reg_scoreboard #(.NUM_SRCS(2), .NUM_WB(2), .WB_BYPASS(0)) dut0 (.clk(clk), .reset(rst_n), .sb(if0));
    reg_scoreboard #(.NUM_SRCS(2), .NUM_WB(2), .WB_BYPASS(1)) dut1 (.clk(clk), .reset(rst_n), .sb(if1));

    int mcnt [2][NUM_REGS];
    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int wb_hits(input int r);
        int n = 0;
        for (int p = 0; p < 2; p++) if (r != 0 && wb_valid[p] && int'(wb_dst[p]) == r) n++;
        return n;
    endfunction

    function automatic bit model_stall(input int b);
        if (!rst_n || !disp_valid) return 1'b0;
        for (int i = 0; i < 2; i++) begin
            int s = int'(src[i]);
            if (src_valid[i] && s != 0 && mcnt[b][s] != 0
                && !(b == 1 && mcnt[b][s] == 1 && wb_hits(s) > 0)) return 1'b1;
        end
        if (dst_valid && dst != 0 && mcnt[b][int'(dst)] == SB_CNT_MAX
            && !(b == 1 && wb_hits(int'(dst)) > 0)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_mask(input int b);
        logic [31:0] m = '0;
        for (int r = 0; r < NUM_REGS; r++) m[r] = (mcnt[b][r] != 0);
        return m;
    endfunction

    task automatic clr();
        flush = 0; disp_valid = 0; dst_valid = 0; src_valid = '0; src = '0;
        dst = '0; wb_valid = '0; wb_dst = '0;
    endtask

    // Checks the current cycle at the falling edge, then advances the reference counts.
    task automatic tick();
        int nxt [2][NUM_REGS];
        @(negedge clk);
        for (int b = 0; b < 2; b++) begin
            bit es, ef;
            es = model_stall(b);
            ef = rst_n && disp_valid && !es && !flush;
            check_eq($sformatf("stall%0d", b), b ? if1.stall : if0.stall, es);
            check_eq($sformatf("fire%0d", b), b ? if1.disp_fire : if0.disp_fire, ef);
            check_eq($sformatf("mask%0d", b), b ? if1.pending_mask : if0.pending_mask, model_mask(b));
            check_eq($sformatf("idle%0d", b), b ? if1.idle : if0.idle, model_mask(b) == 0);
            for (int r = 0; r < NUM_REGS; r++) begin
                int n;
                n = mcnt[b][r] + ((ef && dst_valid && int'(dst) == r) ? 1 : 0) - wb_hits(r);
                nxt[b][r] = (!rst_n || flush || r == 0 || n < 0) ? 0 : n;
            end
        end
        @(posedge clk);
        #1;
        mcnt = nxt;
    endtask

    initial begin
        int avail [NUM_REGS];
        rst_n = 0;
        clr();
        #1;
        check_eq("rst_stall", if0.stall, 0);
        check_eq("rst_idle", if0.idle, 1);
        repeat (2) tick();
        rst_n = 1;
        tick();

        disp_valid = 1; src_valid = 2'b11; src[0] = 5; src[1] = 6; dst_valid = 1; dst = 7;
        #1;
        check_eq("t1_stall", if0.stall, 0);
        check_eq("t1_fire", if0.disp_fire, 1);
        tick();
        clr();
        #1;
        check_eq("t1_mask", if0.pending_mask, 32'h80);
        check_eq("t1_idle", if0.idle, 0);
        tick();

        disp_valid = 1; src_valid = 2'b01; src[0] = 7;
        #1;
        check_eq("t2_stall0", if0.stall, 1);
        check_eq("t2_stall1", if1.stall, 1);
        repeat (2) tick();
        wb_valid = 2'b01; wb_dst[0] = 7;
        #1;
        check_eq("t2_wb_stall0", if0.stall, 1);
        check_eq("t2_wb_stall1", if1.stall, 0);
        tick();
        wb_valid = '0;
        #1;
        check_eq("t2_after_stall0", if0.stall, 0);
        tick();

        clr();
        disp_valid = 1; dst_valid = 1; dst = 3;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq($sformatf("t3_stall_k%0d", k), if0.stall, k == 3);
            tick();
        end
        clr();
        wb_valid = 2'b11; wb_dst[0] = 3; wb_dst[1] = 3;
        tick();
        clr();
        #1;
        check_eq("t3_cnt", dut0.g_reg[3].u_cnt.o_cnt, 1);
        check_eq("t3_mask3", if0.pending_mask[3], 1);
        wb_valid = 2'b01; wb_dst[0] = 3;
        tick();

        clr();
        disp_valid = 1; dst_valid = 1; dst = 9;
        tick();
        wb_valid = 2'b10; wb_dst[1] = 9;
        tick();
        clr();
        #1;
        check_eq("t4_cnt", dut0.g_reg[9].u_cnt.o_cnt, 1);
        check_eq("t4_cnt_byp", dut1.g_reg[9].u_cnt.o_cnt, 1);
        wb_valid = 2'b01; wb_dst[0] = 9;
        tick();

        clr();
        disp_valid = 1; dst_valid = 1;
        dst = 2; tick();
        dst = 4; tick();
        dst = 8; tick();
        flush = 1; dst = 5;
        #1;
        check_eq("t5_fire", if0.disp_fire, 0);
        tick();
        clr();
        #1;
        check_eq("t5_mask", if0.pending_mask, 0);
        check_eq("t5_idle", if0.idle, 1);

        disp_valid = 1; src_valid = 2'b01; src[0] = 0; dst_valid = 1; dst = 0;
        wb_valid = 2'b01; wb_dst[0] = 0;
        #1;
        check_eq("t6_stall", if0.stall, 0);
        tick();
        clr();
        #1;
        check_eq("t6_mask", if0.pending_mask, 0);

        repeat (400) begin
            disp_valid   = ($urandom_range(0, 3) != 0);
            src_valid    = 2'($urandom);
            src[0]       = REG_W'($urandom_range(0, 9));
            src[1]       = REG_W'($urandom_range(0, 9));
            dst_valid    = ($urandom_range(0, 3) != 0);
            dst          = REG_W'($urandom_range(0, 9));
            flush        = ($urandom_range(0, 31) == 0);
            for (int r = 0; r < NUM_REGS; r++) avail[r] = (mcnt[0][r] < mcnt[1][r]) ? mcnt[0][r] : mcnt[1][r];
            for (int p = 0; p < 2; p++) begin
                int r = $urandom_range(0, 9);
                wb_dst[p]   = REG_W'(r);
                wb_valid[p] = ($urandom_range(0, 1) == 1) && (r == 0 || avail[r] > 0);
                if (wb_valid[p] && r != 0) avail[r]--;
            end
            tick();
        end

        clr();
        disp_valid = 1; dst_valid = 1; dst = 6;
        tick();
        rst_n = 0;
        #1;
        check_eq("t6_rst_stall", if0.stall, 0);
        check_eq("t6_rst_fire", if1.disp_fire, 0);
        check_eq("t6_rst_mask", if0.pending_mask, 0);
        check_eq("t6_rst_idle", if1.idle, 1);
        for (int b = 0; b < 2; b++) for (int r = 0; r < NUM_REGS; r++) mcnt[b][r] = 0;
        tick();
        rst_n = 1;
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
